// File: rtl/mux4_pkg.sv
// Shared types and helpers for the mux4 slice: select-code type and change test.
package mux4_pkg;

  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic sel_changed(input sel_t a, input sel_t b);
    return (a != b);
  endfunction

endpackage

// File: rtl/mux4_if.sv
// Bundle of mux4 data, select, enable and result signals for connecting a driver to the mux.
interface mux4_if
  import mux4_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  sel_t             sel;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  sel_t             sel_q;
  logic             chg;

  modport master (
    output d0, d1, d2, d3, sel, en,
    input  out, out_q, sel_q, chg
  );

  modport slave (
    input  d0, d1, d2, d3, sel, en,
    output out, out_q, sel_q, chg
  );

endinterface

// File: rtl/mux4_sel.sv
// Purely combinational 4:1 selector; an unknown select propagates X rather than picking an input.
module mux4_sel
  import mux4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_0,
  input  logic [WIDTH-1:0] i_1,
  input  logic [WIDTH-1:0] i_2,
  input  logic [WIDTH-1:0] i_3,
  input  sel_t             i_sel,
  output logic [WIDTH-1:0] o_out
);

  localparam sel_t SEL_0 = 2'd0;
  localparam sel_t SEL_1 = 2'd1;
  localparam sel_t SEL_2 = 2'd2;
  localparam sel_t SEL_3 = 2'd3;

  always_comb begin
    o_out = 'x;
    case (i_sel)
      SEL_0:   o_out = i_0;
      SEL_1:   o_out = i_1;
      SEL_2:   o_out = i_2;
      SEL_3:   o_out = i_3;
      default: o_out = 'x;
    endcase
  end

endmodule

// File: rtl/mux4.sv
// 4:1 mux with zero-latency output plus an enabled capture register and a select-change pulse.
module mux4
  import mux4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_0,
  input  logic [WIDTH-1:0] i_1,
  input  logic [WIDTH-1:0] i_2,
  input  logic [WIDTH-1:0] i_3,
  input  sel_t             i_sel,
  input  logic             i_en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output sel_t             o_sel_q,
  output logic             o_chg
);

  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] r_out_q;
  sel_t             r_sel_q;
  logic             r_chg;

  mux4_sel #(
    .WIDTH (WIDTH)
  ) u_sel (
    .i_0   (i_0),
    .i_1   (i_1),
    .i_2   (i_2),
    .i_3   (i_3),
    .i_sel (i_sel),
    .o_out (w_out)
  );

  // The change pulse compares against the previously captured select, so it lasts one edge only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_q <= '0;
      r_sel_q <= '0;
      r_chg   <= 1'b0;
    end else if (i_en) begin
      r_out_q <= w_out;
      r_sel_q <= i_sel;
      r_chg   <= sel_changed(i_sel, r_sel_q);
    end else begin
      r_chg   <= 1'b0;
    end
  end

  assign out     = w_out;
  assign out_q   = r_out_q;
  assign o_sel_q = r_sel_q;
  assign o_chg   = r_chg;

endmodule

// File: tb/tb_mux4.sv
// Scoreboard bench for mux4: directed scenarios, WIDTH=1/32 pass-through, then randomized traffic.
module tb_mux4;
  import mux4_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [1:0]   s;
    logic         c;
  } exp_t;

  logic clk     = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n;
  int   checks  = 0;
  int   errors  = 0;

  mux4_if #(.WIDTH(W)) bus ();

  logic [W-1:0] dm [4];
  exp_t         sb [$];

  // reference state: what a capture register holding the last enabled select/data would show
  logic [W-1:0] m_q = '0;
  logic [1:0]   m_s = '0;
  logic         m_c = 1'b0;

  logic [0:0]  n_d [4];
  logic [31:0] w_d [4];
  logic [1:0]  wsel;
  logic        wen = 1'b0;
  logic [0:0]  n_out, n_q;
  logic [1:0]  n_sq;
  logic        n_c;
  logic [31:0] w_out, w_q;
  logic [1:0]  w_sq;
  logic        w_c;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  mux4 #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_0     (bus.d0),
    .i_1     (bus.d1),
    .i_2     (bus.d2),
    .i_3     (bus.d3),
    .i_sel   (bus.sel),
    .i_en    (bus.en),
    .out     (bus.out),
    .out_q   (bus.out_q),
    .o_sel_q (bus.sel_q),
    .o_chg   (bus.chg)
  );

  mux4 #(.WIDTH(1)) dut_n (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_0     (n_d[0]),
    .i_1     (n_d[1]),
    .i_2     (n_d[2]),
    .i_3     (n_d[3]),
    .i_sel   (wsel),
    .i_en    (wen),
    .out     (n_out),
    .out_q   (n_q),
    .o_sel_q (n_sq),
    .o_chg   (n_c)
  );

  mux4 #(.WIDTH(32)) dut_w (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_0     (w_d[0]),
    .i_1     (w_d[1]),
    .i_2     (w_d[2]),
    .i_3     (w_d[3]),
    .i_sel   (wsel),
    .i_en    (wen),
    .out     (w_out),
    .out_q   (w_q),
    .o_sel_q (w_sq),
    .o_chg   (w_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.d0 = dm[0];
    bus.d1 = dm[1];
    bus.d2 = dm[2];
    bus.d3 = dm[3];
  endtask

  task automatic check_out(input string name);
    #1;
    check(name, {24'd0, bus.out}, {24'd0, dm[bus.sel]});
  endtask

  task automatic check_wide(input string tag);
    for (int s = 0; s < 4; s++) begin
      wsel = 2'(s);
      #1;
      check({tag, "_w1"}, {31'd0, n_out}, {31'd0, n_d[s]});
      check({tag, "_w32"}, w_out, w_d[s]);
    end
  endtask

  // reference model
  always @(negedge rst_n) begin
    m_q = '0;
    m_s = '0;
    m_c = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q = '0;
      m_s = '0;
      m_c = 1'b0;
    end else if (bus.en) begin
      m_c = (bus.sel != m_s);
      m_q = dm[bus.sel];
      m_s = bus.sel;
    end else begin
      m_c = 1'b0;
    end
    sb.push_back('{q: m_q, s: m_s, c: m_c});
  end

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow actual=0 required=1 t=%0t", $time);
      end else begin
        e = sb.pop_front();
        check("mon_out_q", {24'd0, bus.out_q}, {24'd0, e.q});
        check("mon_sel_q", {30'd0, bus.sel_q}, {30'd0, e.s});
        check("mon_chg", {31'd0, bus.chg}, {31'd0, e.c});
      end
    end
  end

  initial begin
    logic rst_pend;
    dm[0] = 8'd10; dm[1] = 8'd11; dm[2] = 8'd12; dm[3] = 8'd13;
    drive();

    // select sweep with no clock or reset activity
    for (int s = 0; s < 4; s++) begin
      bus.sel = 2'(s);
      #5;
      check("sweep", {24'd0, bus.out}, 32'd10 + 32'(s));
      #5;
    end

    n_d[0] = 1'b1; n_d[1] = 1'b0; n_d[2] = 1'b1; n_d[3] = 1'b0;
    w_d[0] = 32'hDEADBEEF; w_d[1] = 32'h12345678;
    w_d[2] = 32'h80000001; w_d[3] = 32'h0F0FF0F0;
    check_wide("param_a");
    n_d[0] = 1'b0; n_d[1] = 1'b1; n_d[2] = 1'b0; n_d[3] = 1'b1;
    for (int i = 0; i < 4; i++) w_d[i] = ~w_d[i];
    check_wide("param_b");

    bus.en  = 1'b0;
    bus.sel = 2'd0;
    rst_n   = 1'b0;
    #1;
    check("rst_out_q", {24'd0, bus.out_q}, 32'd0);
    check("rst_sel_q", {30'd0, bus.sel_q}, 32'd0);
    check("rst_chg", {31'd0, bus.chg}, 32'd0);
    clk_run = 1'b1;
    repeat (3) @(negedge clk);

    // first capture after reset release
    rst_n   = 1'b1;
    bus.en  = 1'b1;
    bus.sel = 2'd2;
    @(negedge clk);
    check("cap_out_q", {24'd0, bus.out_q}, 32'd12);
    check("cap_sel_q", {30'd0, bus.sel_q}, 32'd2);
    check("cap_chg", {31'd0, bus.chg}, 32'd1);
    @(negedge clk);
    check("cap_chg_drop", {31'd0, bus.chg}, 32'd0);

    // enable low holds captured state
    bus.en  = 1'b0;
    bus.sel = 2'd3;
    #1;
    check("hold_out", {24'd0, bus.out}, 32'd13);
    repeat (5) begin
      @(negedge clk);
      check("hold_out_q", {24'd0, bus.out_q}, 32'd12);
      check("hold_chg", {31'd0, bus.chg}, 32'd0);
    end

    // data change with fixed select
    bus.en  = 1'b1;
    bus.sel = 2'd1;
    @(negedge clk);
    dm[1] = 8'd55;
    drive();
    #1;
    check("dchg_out", {24'd0, bus.out}, 32'd55);
    @(negedge clk);
    check("dchg_out_q", {24'd0, bus.out_q}, 32'd55);
    check("dchg_chg", {31'd0, bus.chg}, 32'd0);

    // async reset mid-cycle while a change pulse is live
    bus.sel = 2'd3;
    @(negedge clk);
    check("pre_rst_out_q", {24'd0, bus.out_q}, 32'd13);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_q", {24'd0, bus.out_q}, 32'd0);
    check("arst_sel_q", {30'd0, bus.sel_q}, 32'd0);
    check("arst_chg", {31'd0, bus.chg}, 32'd0);
    bus.sel = 2'd0;
    #1;
    check("arst_out", {24'd0, bus.out}, 32'd10);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic with occasional resets
    rst_pend = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (rst_pend) begin
        rst_n    = 1'b1;
        rst_pend = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        rst_n    = 1'b0;
        rst_pend = 1'b1;
      end
      for (int i = 0; i < 4; i++) dm[i] = W'($urandom);
      drive();
      bus.sel = 2'($urandom_range(0, 3));
      bus.en  = ($urandom_range(0, 3) != 0);
      check_out("rnd_out");
      if (n % 16 == 0) begin
        for (int i = 0; i < 4; i++) begin
          w_d[i] = $urandom;
          n_d[i] = 1'($urandom);
        end
        wsel = 2'($urandom_range(0, 3));
        #1;
        check("rnd_w32", w_out, w_d[wsel]);
        check("rnd_w1", {31'd0, n_out}, {31'd0, n_d[wsel]});
      end
    end

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4.md
MUX4 -- requirements
Module: mux4

Interface
REQ-001 Parameter WIDTH, default 8, data width of every data input and data output.
REQ-002 i_clk  input  1  single clock; all sequential logic updates on the rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_0  input  WIDTH  data input selected when i_sel = 0.
REQ-005 i_1  input  WIDTH  data input selected when i_sel = 1.
REQ-006 i_2  input  WIDTH  data input selected when i_sel = 2.
REQ-007 i_3  input  WIDTH  data input selected when i_sel = 3.
REQ-008 i_sel  input  2  select code.
REQ-009 i_en  input  1  capture enable for the registered outputs; active-high.
REQ-010 out  output  WIDTH  combinational selected data.
REQ-011 out_q  output  WIDTH  registered copy of out.
REQ-012 o_sel_q  output  2  registered copy of i_sel.
REQ-013 o_chg  output  1  one-cycle pulse when a captured select differs from the previous captured select.

Function
REQ-014 out SHALL equal i_0/i_1/i_2/i_3 for i_sel = 0/1/2/3, with zero latency.
REQ-015 out SHALL depend only on i_0..i_3 and i_sel, independent of i_clk, i_rst_n and i_en, including while they are undriven or X.
REQ-016 If i_sel contains X/Z, out SHALL be X in simulation; no X-masking.
REQ-017 On a rising i_clk edge with i_en=1 and i_rst_n=1, out_q SHALL load out and o_sel_q SHALL load i_sel; latency one cycle.
REQ-018 With i_en=0, out_q and o_sel_q SHALL hold their values.
REQ-019 On a capture edge, o_chg SHALL become 1 for exactly one cycle if i_sel differs from the current o_sel_q; otherwise it SHALL become 0.
REQ-020 o_chg SHALL be 0 on every edge with i_en=0.
REQ-021 The first capture after reset SHALL compare against the reset value of o_sel_q (0).
REQ-022 A change on a data input with i_sel unchanged SHALL update out immediately and out_q on the next enabled edge, without asserting o_chg.
REQ-023 Data SHALL pass through unmodified: no sign extension, truncation or arithmetic for any WIDTH >= 1.

Reset
REQ-024 While i_rst_n=0, out_q, o_sel_q and o_chg SHALL be 0, asynchronously and without waiting for a clock edge.
REQ-025 out SHALL remain combinationally valid during reset.
REQ-026 Deassertion of i_rst_n SHALL take effect on the next rising edge; the first capture occurs on that edge if i_en=1.
REQ-027 Reset asserted mid-operation SHALL clear the registered outputs immediately, including an o_chg pulse in progress.

Structure
REQ-028 No shared package is required; the select encodings 0..3 SHALL be local constants.
REQ-029 The combinational selector SHALL be a sub-module named mux4_sel, parameterised by WIDTH.
REQ-030 mux4 SHALL instantiate mux4_sel and add the capture, change-detect and reset logic around it.
REQ-031 The design SHALL be synthesizable with no latches; every case branch and default SHALL be assigned.

Verification
REQ-032 Sweep: WIDTH=8, inputs 10/11/12/13, no clock or reset driven; i_sel = 0,1,2,3 held 10 ns each -> out = 10,11,12,13 within each step.
REQ-033 Capture: reset released, i_en=1, i_sel=2 -> out_q=12 and o_sel_q=2 after one edge, o_chg=1 for one cycle, then o_chg=0 with i_sel held.
REQ-034 Enable hold: i_en=0, i_sel changed 2->3 -> out=13 immediately; out_q stays 12 and o_chg stays 0 across 5 edges.
REQ-035 Data change: i_sel fixed at 1, i_1 changes 11->55 -> out=55 immediately, out_q=55 after the next enabled edge, o_chg=0.
REQ-036 Async reset: i_rst_n pulled low between edges while out_q=13 -> out_q=0, o_sel_q=0 and o_chg=0 with no clock edge; out still follows i_sel.
REQ-037 Parameter: WIDTH=1 and WIDTH=32 with distinct patterns on every input -> exact pass-through for all four selects.
